monitor_contador: RTL and testbench



---
 rtl/monitor_contador.sv | 173 +++++++++++++++++
 tb/tb_monitor_contador.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_contador.sv
// -----------------------------------------------------------------------------
// monitor_contador
//
// Cycle-accurate checker for the 16-bit programmable counter. It snapshots the
// counter's command (ENB, MODO, D) and current output Q at every rising CLK
// edge. At the next edge it compares the counter's Q, RCO and Paridad with a
// golden model evaluated from that snapshot.
//
// Ports
//   CLK, RST_L          clock (rising edge), asynchronous active-low reset
//   ENB, MODO, D        counter command inputs (same nets as the counter)
//     MODO: 00 = +1, 01 = -1, 10 = +3, 11 = load D
//   Q, RCO, Paridad     counter outputs under observation
//   SINCRONIZADO        high while in CHECK
//   FALLA               high while in FAIL (sticky until reset)
//   ERR_Q/RCO/PAR       one-cycle mismatch pulses
//   ERR_CNT             saturating count of cycles with any mismatch
//   RCO_CNT             wrapping count of RCO-high cycles seen while checking
//
// SINCRONIZADO/FALLA together expose the FSM state:
//   00 = IDLE, 10 = CHECK, 01 = FAIL.
// -----------------------------------------------------------------------------
module monitor_contador #(
  parameter int ANCHO   = 16,
  parameter int MAX_ERR = 8
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [ANCHO-1:0] D,
  input  logic [ANCHO-1:0] Q,
  input  logic             RCO,
  input  logic             Paridad,
  output logic             SINCRONIZADO,
  output logic             FALLA,
  output logic             ERR_Q,
  output logic             ERR_RCO,
  output logic             ERR_PAR,
  output logic [7:0]       ERR_CNT,
  output logic [15:0]      RCO_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } estado_t;

  localparam logic [ANCHO-1:0] TODO_UNOS = {ANCHO{1'b1}};
  // Lowest Q from which a +3 step wraps past all-ones.
  localparam logic [ANCHO-1:0] TOPE_MAS3 = {ANCHO{1'b1}} - ANCHO'(2);

  estado_t          state_q, state_d;
  logic             p_enb_q, p_enb_d;
  logic [1:0]       p_modo_q, p_modo_d;
  logic [ANCHO-1:0] p_d_q, p_d_d;
  logic [ANCHO-1:0] p_q_q, p_q_d;
  logic             err_q_q, err_q_d;
  logic             err_rco_q, err_rco_d;
  logic             err_par_q, err_par_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [15:0]      rco_cnt_q, rco_cnt_d;
  logic             sinc_q, sinc_d;
  logic             falla_q, falla_d;

  logic [ANCHO-1:0] exp_q;
  logic             exp_rco;
  logic             mism_q, mism_rco, mism_par, mism_any;
  logic             activo;

  always_comb begin
    // Golden model evaluated from the previous edge's snapshot.
    exp_q   = p_q_q;
    exp_rco = 1'b0;
    if (p_enb_q) begin
      case (p_modo_q)
        2'b00: begin
          exp_q   = p_q_q + ANCHO'(1);
          exp_rco = (p_q_q == TODO_UNOS);
        end
        2'b01: begin
          exp_q   = p_q_q - ANCHO'(1);
          exp_rco = (p_q_q == '0);
        end
        2'b10: begin
          exp_q   = p_q_q + ANCHO'(3);
          exp_rco = (p_q_q >= TOPE_MAS3);
        end
        default: begin
          exp_q   = p_d_q;   // a load never raises RCO
          exp_rco = 1'b0;
        end
      endcase
    end

    mism_q   = (Q != exp_q);
    mism_rco = (RCO != exp_rco);
    mism_par = (Paridad != ^Q);   // parity is checked on the live Q only
    mism_any = mism_q | mism_rco | mism_par;
    activo   = (state_q != ST_IDLE);

    p_enb_d  = ENB;
    p_modo_d = MODO;
    p_d_d    = D;
    p_q_d    = Q;

    state_d   = state_q;
    err_q_d   = 1'b0;
    err_rco_d = 1'b0;
    err_par_d = 1'b0;
    err_cnt_d = err_cnt_q;
    rco_cnt_d = rco_cnt_q;

    if (activo) begin
      err_q_d   = mism_q;
      err_rco_d = mism_rco;
      err_par_d = mism_par;
      // One increment per faulty cycle regardless of how many checks failed.
      if (mism_any && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      if (RCO) rco_cnt_d = rco_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE:  if (ENB && (MODO == 2'b11)) state_d = ST_CHECK;
      ST_CHECK: if (mism_any && (err_cnt_d == 8'(MAX_ERR))) state_d = ST_FAIL;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase

    sinc_d  = (state_d == ST_CHECK);
    falla_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q   <= ST_IDLE;
      p_enb_q   <= 1'b0;
      p_modo_q  <= 2'b00;
      p_d_q     <= '0;
      p_q_q     <= '0;
      err_q_q   <= 1'b0;
      err_rco_q <= 1'b0;
      err_par_q <= 1'b0;
      err_cnt_q <= 8'd0;
      rco_cnt_q <= 16'd0;
      sinc_q    <= 1'b0;
      falla_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_enb_q   <= p_enb_d;
      p_modo_q  <= p_modo_d;
      p_d_q     <= p_d_d;
      p_q_q     <= p_q_d;
      err_q_q   <= err_q_d;
      err_rco_q <= err_rco_d;
      err_par_q <= err_par_d;
      err_cnt_q <= err_cnt_d;
      rco_cnt_q <= rco_cnt_d;
      sinc_q    <= sinc_d;
      falla_q   <= falla_d;
    end
  end

  assign SINCRONIZADO = sinc_q;
  assign FALLA        = falla_q;
  assign ERR_Q        = err_q_q;
  assign ERR_RCO      = err_rco_q;
  assign ERR_PAR      = err_par_q;
  assign ERR_CNT      = err_cnt_q;
  assign RCO_CNT      = rco_cnt_q;

endmodule

// File: tb/tb_monitor_contador.sv
// -----------------------------------------------------------------------------
// tb_monitor_contador
//
// Directed bench for monitor_contador (ANCHO=16, MAX_ERR=8). A well-behaved
// counter is emulated here to produce Q/RCO/Paridad; faults are planted by
// overriding the emulated Q or flipping RCO/Paridad for a single cycle.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_monitor_contador;

  logic        CLK;
  logic        RST_L;
  logic        ENB;
  logic [1:0]  MODO;
  logic [15:0] D;
  logic [15:0] Q;
  logic        RCO;
  logic        Paridad;
  logic        SINCRONIZADO;
  logic        FALLA;
  logic        ERR_Q;
  logic        ERR_RCO;
  logic        ERR_PAR;
  logic [7:0]  ERR_CNT;
  logic [15:0] RCO_CNT;

  monitor_contador #(.ANCHO(16), .MAX_ERR(8)) dut (
    .CLK          (CLK),
    .RST_L        (RST_L),
    .ENB          (ENB),
    .MODO         (MODO),
    .D            (D),
    .Q            (Q),
    .RCO          (RCO),
    .Paridad      (Paridad),
    .SINCRONIZADO (SINCRONIZADO),
    .FALLA        (FALLA),
    .ERR_Q        (ERR_Q),
    .ERR_RCO      (ERR_RCO),
    .ERR_PAR      (ERR_PAR),
    .ERR_CNT      (ERR_CNT),
    .RCO_CNT      (RCO_CNT)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // emulated counter state and one-shot fault flags
  logic [15:0] cq;
  logic        crco;
  logic        rco_flip;
  logic        par_flip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic eq, input logic er, input logic ep);
    chk({tag, "_err_q"},   {31'd0, ERR_Q},   {31'd0, eq});
    chk({tag, "_err_rco"}, {31'd0, ERR_RCO}, {31'd0, er});
    chk({tag, "_err_par"}, {31'd0, ERR_PAR}, {31'd0, ep});
  endtask

  task automatic chk_state(input string tag, input logic s, input logic f);
    chk({tag, "_sinc"},  {31'd0, SINCRONIZADO}, {31'd0, s});
    chk({tag, "_falla"}, {31'd0, FALLA},        {31'd0, f});
  endtask

  // driver: present one command plus the counter's current outputs, advance
  // the emulated counter at the edge, then settle 1 ns for sampling
  task automatic cyc(input logic enb, input logic [1:0] modo, input logic [15:0] d);
    logic [15:0] nq;
    logic        nrco;
    ENB     = enb;
    MODO    = modo;
    D       = d;
    Q       = cq;
    RCO     = crco ^ rco_flip;
    Paridad = (^cq) ^ par_flip;
    @(posedge CLK);
    nq   = cq;
    nrco = 1'b0;
    if (enb) begin
      case (modo)
        2'b00: begin nq = cq + 16'd1; nrco = (cq == 16'hFFFF); end
        2'b01: begin nq = cq - 16'd1; nrco = (cq == 16'h0000); end
        2'b10: begin nq = cq + 16'd3; nrco = (cq >= 16'hFFFD); end
        default: nq = d;
      endcase
    end
    cq       = nq;
    crco     = nrco;
    rco_flip = 1'b0;
    par_flip = 1'b0;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_state(tag, 1'b0, 1'b0);
    chk_err(tag, 1'b0, 1'b0, 1'b0);
    chk({tag, "_err_cnt"}, {24'd0, ERR_CNT}, 32'd0);
    chk({tag, "_rco_cnt"}, {16'd0, RCO_CNT}, 32'd0);
  endtask

  initial begin
    RST_L = 1'b0; ENB = 1'b0; MODO = 2'b00; D = '0; Q = '0; RCO = 1'b0; Paridad = 1'b0;
    cq = '0; crco = 1'b0; rco_flip = 1'b0; par_flip = 1'b0;

    // reset state
    #12;
    chk_all_zero("reset");
    @(negedge CLK);
    RST_L = 1'b1;

    // sync on load of 0, then 20 correct up-counts
    cyc(1'b1, 2'b11, 16'h0000);
    chk_state("sync", 1'b1, 1'b0);
    chk("sync_err_cnt", {24'd0, ERR_CNT}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 2'b00, 16'h0000);
      chk_err("up", 1'b0, 1'b0, 1'b0);
    end
    chk("up_err_cnt", {24'd0, ERR_CNT}, 32'd0);
    chk("up_rco_cnt", {16'd0, RCO_CNT}, 32'd0);

    // up wrap: FFFE, FFFF, 0000 (RCO)
    cyc(1'b1, 2'b11, 16'hFFFE);
    cyc(1'b1, 2'b00, 16'h0000);
    cyc(1'b1, 2'b00, 16'h0000);
    chk("wrap_up_pre_rco", {16'd0, RCO_CNT}, 32'd0);
    cyc(1'b1, 2'b00, 16'h0000);
    chk("wrap_up_rco_cnt", {16'd0, RCO_CNT}, 32'd1);
    chk_err("wrap_up", 1'b0, 1'b0, 1'b0);

    // down wrap: 0001, 0000, FFFF (RCO)
    cyc(1'b1, 2'b11, 16'h0001);
    cyc(1'b1, 2'b01, 16'h0000);
    cyc(1'b1, 2'b01, 16'h0000);
    cyc(1'b1, 2'b01, 16'h0000);
    chk("wrap_dn_rco_cnt", {16'd0, RCO_CNT}, 32'd2);
    chk_err("wrap_dn", 1'b0, 1'b0, 1'b0);

    // +3 wrap: FFFD, 0000 (RCO)
    cyc(1'b1, 2'b11, 16'hFFFD);
    cyc(1'b1, 2'b10, 16'h0000);
    cyc(1'b1, 2'b10, 16'h0000);
    chk("wrap_p3_rco_cnt", {16'd0, RCO_CNT}, 32'd3);
    chk_err("wrap_p3", 1'b0, 1'b0, 1'b0);
    chk("wrap_err_cnt", {24'd0, ERR_CNT}, 32'd0);

    // Q fault: 0005 presented where 0004 is expected
    cyc(1'b1, 2'b11, 16'h0003);
    cyc(1'b1, 2'b00, 16'h0000);
    cq = 16'h0005;
    cyc(1'b1, 2'b00, 16'h0000);
    chk_err("fq", 1'b1, 1'b0, 1'b0);
    chk("fq_err_cnt", {24'd0, ERR_CNT}, 32'd1);
    cyc(1'b1, 2'b00, 16'h0000);
    chk_err("fq_after", 1'b0, 1'b0, 1'b0);
    chk("fq_after_err_cnt", {24'd0, ERR_CNT}, 32'd1);

    // Paridad fault on Q=0003
    cyc(1'b1, 2'b11, 16'h0003);
    par_flip = 1'b1;
    cyc(1'b1, 2'b00, 16'h0000);
    chk_err("fpar", 1'b0, 1'b0, 1'b1);
    chk("fpar_err_cnt", {24'd0, ERR_CNT}, 32'd2);

    // simultaneous Q and RCO fault: one ERR_CNT step
    cq = 16'h0009;
    rco_flip = 1'b1;
    cyc(1'b1, 2'b00, 16'h0000);
    chk_err("fqr", 1'b1, 1'b1, 1'b0);
    chk("fqr_err_cnt", {24'd0, ERR_CNT}, 32'd3);
    chk("fqr_rco_cnt", {16'd0, RCO_CNT}, 32'd4);

    // ENB low with Q held
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'b00, 16'h0000);
      chk_err("hold", 1'b0, 1'b0, 1'b0);
    end
    chk("hold_rco_cnt", {16'd0, RCO_CNT}, 32'd4);
    chk("hold_err_cnt", {24'd0, ERR_CNT}, 32'd3);

    // ENB low but Q keeps incrementing
    cq = cq + 16'd1;
    cyc(1'b0, 2'b00, 16'h0000);
    chk_err("drift1", 1'b1, 1'b0, 1'b0);
    cq = cq + 16'd1;
    cyc(1'b0, 2'b00, 16'h0000);
    chk_err("drift2", 1'b1, 1'b0, 1'b0);
    chk("drift_err_cnt", {24'd0, ERR_CNT}, 32'd5);
    chk_state("drift", 1'b1, 1'b0);

    // asynchronous reset mid-check
    #2;
    RST_L = 1'b0;
    #1;
    chk_all_zero("rst_check");
    @(negedge CLK);
    RST_L = 1'b1;
    cq = '0; crco = 1'b0;

    // FAIL entry after exactly MAX_ERR faulty cycles
    cyc(1'b1, 2'b11, 16'h0100);
    chk_state("resync", 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cq = cq + 16'd1;
      cyc(1'b1, 2'b00, 16'h0000);
      chk("fail_err_cnt", {24'd0, ERR_CNT}, i);
      chk_state("fail_entry", (i != 8), (i == 8));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'b00, 16'h0000);
      chk_err("fail_clean", 1'b0, 1'b0, 1'b0);
      chk_state("fail_sticky", 1'b0, 1'b1);
    end
    chk("fail_clean_err_cnt", {24'd0, ERR_CNT}, 32'd8);

    // saturation past 255 faulty cycles
    for (int i = 9; i <= 270; i++) begin
      cq = cq + 16'd1;
      cyc(1'b1, 2'b00, 16'h0000);
      chk("sat_err_cnt", {24'd0, ERR_CNT}, (i > 255) ? 32'd255 : i);
    end
    chk_state("sat", 1'b0, 1'b1);
    chk_err("sat_last", 1'b1, 1'b0, 1'b0);

    // asynchronous reset while in FAIL
    #2;
    RST_L = 1'b0;
    #1;
    chk_all_zero("rst_fail");
    @(negedge CLK);
    RST_L = 1'b1;

    // mismatches while IDLE are ignored; non-load commands do not sync
    cq = 16'h1234;
    rco_flip = 1'b1;
    par_flip = 1'b1;
    cyc(1'b1, 2'b00, 16'h0000);
    chk_all_zero("idle1");
    cq = 16'h7777;
    rco_flip = 1'b1;
    cyc(1'b0, 2'b11, 16'h0000);
    chk_all_zero("idle2");
    cq = 16'h0042;
    par_flip = 1'b1;
    cyc(1'b1, 2'b10, 16'h0000);
    chk_all_zero("idle3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
